npc_lsu: RTL and testbench

- Multi-cycle load/store unit for the NPC core.
- Replaces the hardwired per-cycle memory accesses with a valid/ready request/response path on the core side and a handshaked bus on the memory side.
- Supports every RV load/store width, with sign/zero extension, byte-lane mask generation, bus-error reporting and a watchdog timeout.

---
 rtl/npc_lsu_if.sv | 48 ++++
 rtl/npc_lsu.sv | 178 +++++++++++++++++
 tb/tb_npc_lsu.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/npc_lsu_if.sv
// npc_lsu_if: bundles the core-side request/response channel and the
// memory-side bus of the NPC load/store unit.
//   modport slave  - the LSU view (takes requests, drives the memory bus)
//   modport master - the environment view (core plus memory)
// Request : req_valid/req_ready, req_wen, req_size, req_unsigned, req_addr, req_wdata
// Response: resp_valid/resp_ready, resp_rdata, resp_cause
// Memory  : mem_valid/mem_ready, mem_wen, mem_addr, mem_wdata, mem_wmask,
//           mem_rvalid, mem_rdata, mem_err
interface npc_lsu_if #(
    parameter int XLEN = 64
) ();
    localparam int BYTES = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic [1:0]        resp_cause;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [BYTES-1:0]  mem_wmask;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    modport slave (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_ready, mem_rvalid, mem_rdata, mem_err,
        output req_ready, resp_valid, resp_rdata, resp_cause,
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_ready, mem_rvalid, mem_rdata, mem_err,
        input  req_ready, resp_valid, resp_rdata, resp_cause,
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/npc_lsu.sv
// npc_lsu: multi-cycle load/store unit for the NPC core.
// Accepts one request at a time (valid/ready), issues one handshaked bus
// transaction, waits for the completion (read data or write ack), then holds
// a response until the core takes it. Handles B/H/W/D widths, byte-lane
// masks, sign/zero extension, bus errors and a watchdog timeout.
// Ports: clk, rst (synchronous, active-high), bus (npc_lsu_if.slave).
// Parameters: XLEN (32 or 64), TIMEOUT_CYC (0 disables the watchdog).
// Build option: NPC_LSU_MISALIGN_TRAP_EN - when defined, misaligned accesses
// complete immediately with cause 1; otherwise the address is aligned down.
// All outputs are registered; each is loaded from the next-state decision.
module npc_lsu #(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic      clk,
    input  logic      rst,
    npc_lsu_if.slave  bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Count value in the last allowed REQ/WAIT cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    state_t state_reg, state_next;

    // Latched request and registered outputs
    logic              wen_reg, uns_reg;
    logic [1:0]        size_reg;
    logic [OFF_W-1:0]  off_reg;
    logic [WD_W-1:0]   wd_cnt_reg;
    logic              req_ready_reg, resp_valid_reg, mem_valid_reg, mem_wen_reg;
    logic [XLEN-1:0]   resp_rdata_reg, mem_addr_reg, mem_wdata_reg;
    logic [1:0]        resp_cause_reg;
    logic [BYTES-1:0]  mem_wmask_reg;

    // Request decode
    logic [OFF_W-1:0]  req_off, size_lsb, eff_off;
    logic              illegal_size, cause1;
    logic              accept, done, timeout_hit;
    int                nbytes;
    logic [BYTES-1:0]  lane_hit;

    // Next values of the response registers and the load extractor
    logic [XLEN-1:0]   resp_rdata_next, ld_shift, ld_keep, ld_data;
    logic [1:0]        resp_cause_next;
    logic              ld_sign;

    assign accept      = (state_reg == IDLE) && bus.req_valid;
    // Completion is only honoured once the request has been (or is being) accepted.
    assign done        = (((state_reg == REQ) && bus.mem_ready) || (state_reg == WAIT)) && bus.mem_rvalid;
    assign timeout_hit = (TIMEOUT_CYC != 0) && ((state_reg == REQ) || (state_reg == WAIT))
                         && (wd_cnt_reg == WD_LAST);

    always_comb begin
        req_off      = bus.req_addr[OFF_W-1:0];
        size_lsb     = OFF_W'((1 << bus.req_size) - 1);
        nbytes       = 1 << bus.req_size;
        illegal_size = (XLEN == 32) && (bus.req_size == 2'd3);
`ifdef NPC_LSU_MISALIGN_TRAP_EN
        cause1  = illegal_size || (|(req_off & size_lsb));
        eff_off = req_off;
`else
        cause1  = illegal_size;
        eff_off = req_off & ~size_lsb;
`endif
    end

    // A lane is written when it falls inside [eff_off, eff_off + n).
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign lane_hit[gi] = (gi >= int'(eff_off)) && (gi < int'(eff_off) + nbytes);
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; completion wins over a simultaneous timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.req_valid) state_next = cause1 ? RESP : REQ;
            REQ: begin
                if (done || timeout_hit) state_next = RESP;
                else if (bus.mem_ready)  state_next = WAIT;
            end
            WAIT: if (done || timeout_hit) state_next = RESP;
            RESP: if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: load extraction and response register next values
    always_comb begin
        ld_shift = bus.mem_rdata >> {off_reg, 3'b000};
        ld_keep  = '0;
        case (size_reg)
            2'd0:    begin ld_keep[7:0]  = '1; ld_sign = ld_shift[7];  end
            2'd1:    begin ld_keep[15:0] = '1; ld_sign = ld_shift[15]; end
            2'd2:    begin ld_keep[31:0] = '1; ld_sign = ld_shift[31]; end
            default: begin ld_keep       = '1; ld_sign = ld_shift[XLEN-1]; end
        endcase
        ld_data = (ld_shift & ld_keep) | (~ld_keep & {XLEN{ld_sign & ~uns_reg}});

        resp_rdata_next = resp_rdata_reg;
        resp_cause_next = resp_cause_reg;
        if (accept && cause1) begin
            resp_rdata_next = '0;
            resp_cause_next = 2'd1;
        end else if (done) begin
            resp_rdata_next = (bus.mem_err || wen_reg) ? '0 : ld_data;
            resp_cause_next = bus.mem_err ? 2'd2 : 2'd0;
        end else if (timeout_hit) begin
            resp_rdata_next = '0;
            resp_cause_next = 2'd3;
        end else if ((state_reg == RESP) && bus.resp_ready) begin
            resp_rdata_next = '0;
            resp_cause_next = 2'd0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_reg        <= 1'b0;
            uns_reg        <= 1'b0;
            size_reg       <= 2'd0;
            off_reg        <= '0;
            wd_cnt_reg     <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            mem_valid_reg  <= 1'b0;
            mem_wen_reg    <= 1'b0;
            resp_rdata_reg <= '0;
            resp_cause_reg <= 2'd0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_wmask_reg  <= '0;
        end else begin
            req_ready_reg  <= (state_next == IDLE);
            resp_valid_reg <= (state_next == RESP);
            mem_valid_reg  <= (state_next == REQ);
            resp_rdata_reg <= resp_rdata_next;
            resp_cause_reg <= resp_cause_next;
            if (accept) begin
                wen_reg    <= bus.req_wen;
                uns_reg    <= bus.req_unsigned;
                size_reg   <= bus.req_size;
                off_reg    <= eff_off;
                wd_cnt_reg <= '0;
                // Trapped requests never reach the bus, so leave its fields alone.
                if (!cause1) begin
                    mem_wen_reg   <= bus.req_wen;
                    mem_addr_reg  <= {bus.req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    mem_wdata_reg <= bus.req_wdata << {eff_off, 3'b000};
                    mem_wmask_reg <= bus.req_wen ? lane_hit : '0;
                end
            end else if ((state_reg == REQ) || (state_reg == WAIT)) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_cause = resp_cause_reg;
    assign bus.mem_valid  = mem_valid_reg;
    assign bus.mem_wen    = mem_wen_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.mem_wmask  = mem_wmask_reg;
endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: directed self-checking bench for npc_lsu (XLEN=64,
// TIMEOUT_CYC=16). A small in-bench memory responder answers one cycle after
// each bus handshake; expected values are hand-computed constants.
module tb_npc_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    npc_lsu_if #(.XLEN(64)) bus ();

    npc_lsu #(.XLEN(64), .TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Results of the last transaction
    logic [63:0] r_rdata, m_addr, m_wdata;
    logic [1:0]  r_cause;
    logic [7:0]  m_wmask;
    logic        m_wen, m_seen;
    int          r_lat, m_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request and collect the response. hold = cycles to keep
    // resp_ready low once resp_valid appears.
    task automatic run_txn(input string tag, input logic wen, input logic [1:0] size,
                           input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rd, input logic err, input logic mready,
                           input int hold);
        logic hs, got;
        int   cyc;
        check({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
        bus.resp_ready   = (hold == 0);
        bus.mem_ready    = mready;
        bus.mem_rdata    = rd;
        bus.mem_err      = err;
        bus.req_wen      = wen;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        hs = 1'b0; got = 1'b0; cyc = 0;
        m_seen = 1'b0; m_cycles = 0; m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = 1'b0;
        r_rdata = '0; r_cause = '0; r_lat = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.req_valid  = 1'b0;
            bus.mem_rvalid = hs;
            hs = 1'b0;
            if (bus.resp_valid) begin
                got = 1'b1;
                r_lat = cyc;
                r_rdata = bus.resp_rdata;
                r_cause = bus.resp_cause;
            end else if (bus.mem_valid) begin
                m_cycles++;
                if (!m_seen) begin
                    m_addr = bus.mem_addr; m_wdata = bus.mem_wdata;
                    m_wmask = bus.mem_wmask; m_wen = bus.mem_wen;
                end
                m_seen = 1'b1;
                if (bus.mem_ready) hs = 1'b1;
            end
        end
        bus.mem_rvalid = 1'b0;
        if (!got) check({tag, "_resp_bound"}, 64'd0, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {63'd0, bus.resp_valid}, 64'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, r_rdata);
            check({tag, "_hold_cause"}, {62'd0, bus.resp_cause}, {62'd0, r_cause});
            check({tag, "_hold_req_ready"}, {63'd0, bus.req_ready}, 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_resp_clear"}, {63'd0, bus.resp_valid}, 64'd0);
        check({tag, "_idle_ready"}, {63'd0, bus.req_ready}, 64'd1);
        $display("txn %s: lat=%0d cause=%0d rdata=%h mem_seen=%0d addr=%h wmask=%h wdata=%h",
                 tag, r_lat, r_cause, r_rdata, m_seen, m_addr, m_wmask, m_wdata);
    endtask

    initial begin
        logic rv_seen;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1; bus.mem_ready = 1'b1;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store D, aligned
        run_txn("st_d", 1'b1, 2'd3, 1'b0, 64'h80001000, 64'h1122334455667788, 64'h0, 1'b0, 1'b1, 0);
        check("st_d_addr", m_addr, 64'h80001000);
        check("st_d_wmask", {56'd0, m_wmask}, 64'hFF);
        check("st_d_wdata", m_wdata, 64'h1122334455667788);
        check("st_d_wen", {63'd0, m_wen}, 64'd1);
        check("st_d_lat", 64'(r_lat), 64'd3);
        check("st_d_cause", {62'd0, r_cause}, 64'd0);
        check("st_d_rdata", r_rdata, 64'd0);

        // Load B signed / unsigned at offset 3
        run_txn("ld_b_s", 1'b0, 2'd0, 1'b0, 64'h80001003, 64'h0, 64'h0000000080000000, 1'b0, 1'b1, 0);
        check("ld_b_s_rdata", r_rdata, 64'hFFFFFFFFFFFFFF80);
        check("ld_b_s_wmask", {56'd0, m_wmask}, 64'h0);
        check("ld_b_s_addr", m_addr, 64'h80001000);
        run_txn("ld_b_u", 1'b0, 2'd0, 1'b1, 64'h80001003, 64'h0, 64'h0000000080000000, 1'b0, 1'b1, 0);
        check("ld_b_u_rdata", r_rdata, 64'h0000000000000080);

        // Store H in the top lanes
        run_txn("st_h", 1'b1, 2'd1, 1'b0, 64'h80001006, 64'hABCD, 64'h0, 1'b0, 1'b1, 0);
        check("st_h_wmask", {56'd0, m_wmask}, 64'hC0);
        check("st_h_wdata", m_wdata, 64'hABCD000000000000);

        // Misaligned load W
        run_txn("ld_w_mis", 1'b0, 2'd2, 1'b0, 64'h80001002, 64'h0, 64'h112233448899AABB, 1'b0, 1'b1, 0);
`ifdef NPC_LSU_MISALIGN_TRAP_EN
        check("ld_w_mis_cause", {62'd0, r_cause}, 64'd1);
        check("ld_w_mis_lat", 64'(r_lat), 64'd1);
        check("ld_w_mis_memv", {63'd0, m_seen}, 64'd0);
        check("ld_w_mis_rdata", r_rdata, 64'd0);
`else
        check("ld_w_mis_cause", {62'd0, r_cause}, 64'd0);
        check("ld_w_mis_addr", m_addr, 64'h80001000);
        check("ld_w_mis_rdata", r_rdata, 64'hFFFFFFFF8899AABB);
        check("ld_w_mis_lat", 64'(r_lat), 64'd3);
`endif

        // Signed halfword and a bus error
        run_txn("ld_h_s", 1'b0, 2'd1, 1'b0, 64'h8000100A, 64'h0, 64'h00000000BEEF0000, 1'b0, 1'b1, 0);
        check("ld_h_s_rdata", r_rdata, 64'hFFFFFFFFFFFFBEEF);
        run_txn("ld_err", 1'b0, 2'd3, 1'b0, 64'h80001008, 64'h0, 64'hDEADBEEFDEADBEEF, 1'b1, 1'b1, 0);
        check("ld_err_cause", {62'd0, r_cause}, 64'd2);
        check("ld_err_rdata", r_rdata, 64'd0);
        check("ld_err_addr", m_addr, 64'h80001008);

        // Watchdog: bus never ready
        run_txn("tmo", 1'b0, 2'd2, 1'b0, 64'h80001010, 64'h0, 64'h0, 1'b0, 1'b0, 0);
        check("tmo_memv_cycles", 64'(m_cycles), 64'd16);
        check("tmo_cause", {62'd0, r_cause}, 64'd3);
        check("tmo_lat", 64'(r_lat), 64'd17);
        check("tmo_rdata", r_rdata, 64'd0);

        // Stray completion in IDLE is ignored
        bus.mem_rvalid = 1'b1; bus.mem_err = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
        @(negedge clk);
        check("stray_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        run_txn("ld_b_top", 1'b0, 2'd0, 1'b1, 64'h80001017, 64'h0, 64'h5A00000000000000, 1'b0, 1'b1, 0);
        check("ld_b_top_rdata", r_rdata, 64'h5A);
        check("ld_b_top_cause", {62'd0, r_cause}, 64'd0);

        // Response back-pressure
        run_txn("hold", 1'b0, 2'd3, 1'b0, 64'h80001020, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1'b1, 5);
        check("hold_rdata", r_rdata, 64'h0123456789ABCDEF);

        // Reset while in WAIT
        bus.mem_ready = 1'b1; bus.req_wen = 1'b0; bus.req_size = 2'd3; bus.req_unsigned = 1'b0;
        bus.req_addr = 64'h80001030; bus.mem_rdata = 64'hFFFF0000FFFF0000; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstw_memv_req", {63'd0, bus.mem_valid}, 64'd1);
        @(negedge clk);
        check("rstw_memv_wait", {63'd0, bus.mem_valid}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rstw_mem_addr", bus.mem_addr, 64'd0);
        check("rstw_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rstw_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
        bus.mem_rvalid = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        rv_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rv_seen = rv_seen | bus.resp_valid;
        end
        check("rstw_no_resp", {63'd0, rv_seen}, 64'd0);
        $display("txn rst_in_wait: abandoned");

        // Normal operation after reset
        run_txn("st_b", 1'b1, 2'd0, 1'b0, 64'h80001005, 64'h77, 64'h0, 1'b0, 1'b1, 0);
        check("st_b_wmask", {56'd0, m_wmask}, 64'h20);
        check("st_b_wdata", m_wdata, 64'h0000770000000000);
        check("st_b_lat", 64'(r_lat), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
